// File: rtl/sample_conditioner_pkg.sv
// Shared width helpers and the saturation function used by the microphone
// front-end and by the PSOLA output stage.
package sample_conditioner_pkg;

  localparam int SAT_W = 64;

  typedef struct packed {
    logic signed [SAT_W-1:0] value;
    logic                    clip;
  } sat_t;

  function automatic int idx_w(input int window_size);
    return (window_size > 1) ? $clog2(window_size) : 1;
  endfunction

  function automatic int gain_w(input int gain_max);
    return (gain_max > 0) ? $clog2(gain_max + 1) : 1;
  endfunction

  // Clamps a sign-extended value into a signed field 'width' bits wide.
  function automatic sat_t sat_to_width(input logic signed [SAT_W-1:0] x,
                                        input int                      width);
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    sat_t                    r;
    max_v   = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v   = -max_v - 64'sd1;
    r.value = x;
    r.clip  = 1'b0;
    if (x > max_v) begin
      r.value = max_v;
      r.clip  = 1'b1;
    end else if (x < min_v) begin
      r.value = min_v;
      r.clip  = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dc_blocker.sv
// Stage 1: leaky DC tracker. Subtracts acc >>> DC_SHIFT from each accepted
// sample and folds the residual back into the accumulator.
module dc_blocker
  import sample_conditioner_pkg::*;
#(
  parameter int IN_WIDTH = 24,
  parameter int DC_SHIFT = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [IN_WIDTH-1:0] sample,
  input  logic                       valid,
  input  logic                       dc_en,
  output logic signed [IN_WIDTH:0]   y,
  output logic                       y_valid
);

  localparam int Y_W   = IN_WIDTH + 1;
  localparam int ACC_W = IN_WIDTH + DC_SHIFT + 1;

  logic signed [ACC_W-1:0] acc;
  logic signed [Y_W-1:0]   x_ext;
  logic signed [Y_W-1:0]   dc;
  logic signed [Y_W-1:0]   diff;

  // NOTE: every signal is assigned on every pass through always_comb, so no
  // path leaves a value unassigned and no latch can be inferred.
  always_comb begin
    x_ext = Y_W'(sample);
    dc    = Y_W'(acc >>> DC_SHIFT);
    diff  = x_ext - dc;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= valid;
      if (valid) begin
        if (dc_en) begin
          y   <= diff;
          acc <= acc + ACC_W'(diff);
        end else begin
          y   <= x_ext;
          acc <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/sample_conditioner.sv
// Microphone front-end: DC removal, runtime gain with saturation, window/hop
// framing and a clip counter, in a two-stage pipeline with full throughput.
module sample_conditioner
  import sample_conditioner_pkg::*;
#(
  parameter int IN_WIDTH    = 24,
  parameter int OUT_WIDTH   = 16,
  parameter int WINDOW_SIZE = 2048,
  parameter int HOP_SIZE    = 512,
  parameter int DC_SHIFT    = 10,
  parameter int GAIN_MAX    = 7
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic signed [IN_WIDTH-1:0]          sample_in,
  input  logic                                valid_in,
  input  logic [gain_w(GAIN_MAX)-1:0]         gain_in,
  input  logic                                dc_en_in,
  output logic signed [OUT_WIDTH-1:0]         sample_out,
  output logic                                valid_out,
  output logic [idx_w(WINDOW_SIZE)-1:0]       index_out,
  output logic                                hop_out,
  output logic [15:0]                         clip_count_out
);

  localparam int GAIN_W = gain_w(GAIN_MAX);
  localparam int IDX_W  = idx_w(WINDOW_SIZE);
  localparam int FULL_W = IN_WIDTH + 1 + GAIN_MAX;
  localparam int SHIFT  = IN_WIDTH - OUT_WIDTH;
  localparam logic [IDX_W-1:0] HOP_MASK = IDX_W'(HOP_SIZE - 1);

  logic signed [IN_WIDTH:0]  y;
  logic                      y_valid;
  logic [GAIN_W-1:0]         g_clamped;
  logic [GAIN_W-1:0]         g_q;
  logic signed [FULL_W-1:0]  scaled;
  logic signed [FULL_W-1:0]  shifted;
  sat_t                      sat;
  logic signed [OUT_WIDTH-1:0] sample_d;
  logic [IDX_W-1:0]          index_cnt;

  dc_blocker #(
    .IN_WIDTH (IN_WIDTH),
    .DC_SHIFT (DC_SHIFT)
  ) u_dc_blocker (
    .clk     (clk_in),
    .rst_n   (rst_in),
    .sample  (sample_in),
    .valid   (valid_in),
    .dc_en   (dc_en_in),
    .y       (y),
    .y_valid (y_valid)
  );

  always_comb begin
    g_clamped = (gain_in > GAIN_W'(GAIN_MAX)) ? GAIN_W'(GAIN_MAX) : gain_in;
  end

  // Gain travels alongside the stage-1 sample so a gain change never
  // affects a sample that was accepted earlier.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      g_q <= '0;
    end else if (valid_in) begin
      g_q <= g_clamped;
    end
  end

  always_comb begin
    scaled   = FULL_W'(y) <<< g_q;
    shifted  = scaled >>> SHIFT;
    sat      = sat_to_width(SAT_W'(shifted), OUT_WIDTH);
    sample_d = OUT_WIDTH'(sat.value);
  end

  // index_cnt is the slot the next emitted sample will occupy; the window
  // length is a power of two, so natural overflow gives the wrap.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sample_out     <= '0;
      valid_out      <= 1'b0;
      index_out      <= '0;
      hop_out        <= 1'b0;
      clip_count_out <= '0;
      index_cnt      <= '0;
    end else begin
      valid_out <= y_valid;
      hop_out   <= y_valid && ((index_cnt & HOP_MASK) == HOP_MASK);
      if (y_valid) begin
        sample_out <= sample_d;
        index_out  <= index_cnt;
        index_cnt  <= index_cnt + 1'b1;
        if (sat.clip && (clip_count_out != 16'hFFFF)) begin
          clip_count_out <= clip_count_out + 16'd1;
        end
      end
    end
  end

endmodule
